// File: rtl/fft_loader_pkg.sv
// Shared state encoding, size defaults and address helper for the FFT input loader.
package fft_loader_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_N_2   = 5;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   // Mirrors the low 'bits' bits of v; the result's upper bits are zero.
   function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int bits);
      logic [31:0] r;
      logic [31:0] t;
      r = '0;
      t = v;
      for (int i = 0; i < 32; i++) begin
         if (i < bits) begin
            r = {r[30:0], t[0]};
            t = t >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_loader_hann_lut.sv
// Hann window coefficient ROM, unsigned Q0.width, one-cycle registered read.
module hann_lut import fft_loader_pkg::*; #(
   parameter int width = DEF_WIDTH,
   parameter int N_2   = DEF_N_2
) (
   input  logic             clk,
   input  logic [N_2-1:0]   idx,
   output logic [width-1:0] out
);

   localparam int  N     = 2 ** N_2;
   localparam real PI    = 3.14159265358979323846;
   localparam int  C_MAX = (1 << width) - 1;

   // The peak value 1.0 is not representable in Q0.width, so it clamps to all-ones.
   function automatic logic [width-1:0] hann_val(input int n);
      real v;
      int  c;
      v = 0.5 * (1.0 - $cos(2.0 * PI * n / N)) * (2.0 ** width);
      c = $rtoi(v + 0.5);
      if (c > C_MAX) c = C_MAX;
      return width'(c);
   endfunction

   logic [width-1:0] rom [N];

   for (genvar i = 0; i < N; i++) begin : g_rom
      localparam logic [width-1:0] COEF = hann_val(i);
      assign rom[i] = COEF;
   end

   logic [width-1:0] out_q;

   always_ff @(posedge clk) begin
      out_q <= rom[idx];
   end

   assign out = out_q;

endmodule

// File: rtl/fft_loader.sv
// Loads windowed audio samples into FFT RAM in bit-reversed order, then hands off to the FFT.
// Define FFT_LOADER_HANN_WINDOW_EN to apply the Hann window; otherwise the window is rectangular.
module fft_loader import fft_loader_pkg::*; #(
   parameter int width = DEF_WIDTH,
   parameter int N_2   = DEF_N_2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [23:0]        sample_in,
   input  logic               sample_valid,
   input  logic               fft_ready,
   input  logic               fft_done,
   output logic               we,
   output logic [N_2-1:0]     adr,
   output logic [2*width-1:0] wd,
   output logic               fft_start,
   output logic               overrun
);

   localparam logic [N_2-1:0] K_LAST = '1;

   state_t                  state_q, state_d;
   logic [N_2-1:0]          k_q, k_d;
   logic                    overrun_q, overrun_d;
   logic                    accept;

   logic                    vld_p0_q, vld_p0_d;
   logic signed [width-1:0] samp_p0_q, samp_p0_d;
   logic [N_2-1:0]          adr_p0_q, adr_p0_d;
   logic signed [width-1:0] real_p0;

   logic                    we_q, we_d;
   logic [N_2-1:0]          adr_q, adr_d;
   logic [2*width-1:0]      wd_q, wd_d;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      overrun_d = overrun_q;
      accept    = 1'b0;
      fft_start = 1'b0;
      unique case (state_q)
         FILL: begin
            if (sample_valid) begin
               accept = 1'b1;
               // k parks at N-1; it only returns to 0 once the FFT has released the RAM
               if (k_q == K_LAST) state_d = START;
               else               k_d     = k_q + 1'b1;
            end
         end
         START: begin
            if (fft_ready && !vld_p0_q && !we_q) begin
               fft_start = 1'b1;
               state_d   = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (fft_done) begin
               state_d = FILL;
               k_d     = '0;
            end
         end
         default: state_d = FILL;
      endcase
      if (sample_valid && (state_q != FILL)) overrun_d = 1'b1;
   end

   // Stage p0: capture sample and write address; the LUT read runs in parallel
   always_comb begin
      vld_p0_d  = accept;
      samp_p0_d = sample_in[23 -: width];
      adr_p0_d  = N_2'(bit_reverse(32'(k_q), N_2));
   end

`ifdef FFT_LOADER_HANN_WINDOW_EN
   logic [width-1:0] coef_p0;

   hann_lut #(.width(width), .N_2(N_2)) u_hann_lut (
      .clk (clk),
      .idx (k_q),
      .out (coef_p0)
   );

   function automatic logic signed [width-1:0] window_mult(
      input logic signed [width-1:0] s,
      input logic        [width-1:0] c
   );
      logic signed [2*width-1:0] p;
      p = $signed({{width{s[width-1]}}, s}) * $signed({{width{1'b0}}, c});
      return width'(p >>> width);
   endfunction

   assign real_p0 = window_mult(samp_p0_q, coef_p0);
`else
   assign real_p0 = samp_p0_q;
`endif

   // Stage p1: windowed product lands in the RAM write port registers
   always_comb begin
      we_d  = vld_p0_q;
      adr_d = adr_q;
      wd_d  = wd_q;
      if (vld_p0_q) begin
         adr_d = adr_p0_q;
         wd_d  = {real_p0, {width{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         k_q       <= '0;
         overrun_q <= 1'b0;
         vld_p0_q  <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         overrun_q <= overrun_d;
         vld_p0_q  <= vld_p0_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wd_q      <= wd_d;
      end
   end

   always_ff @(posedge clk) begin
      samp_p0_q <= samp_p0_d;
      adr_p0_q  <= adr_p0_d;
   end

   assign we      = we_q;
   assign adr     = adr_q;
   assign wd      = wd_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader (N_2=5, width=16); follows FFT_LOADER_HANN_WINDOW_EN when defined.
module tb_fft_loader;

`ifdef FFT_LOADER_HANN_WINDOW_EN
   localparam bit HANN = 1'b1;
`else
   localparam bit HANN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] sample_in;
   logic        sample_valid;
   logic        fft_ready;
   logic        fft_done;
   logic        we;
   logic [4:0]  adr;
   logic [31:0] wd;
   logic        fft_start;
   logic        overrun;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fft_loader #(.width(16), .N_2(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .fft_ready    (fft_ready),
      .fft_done     (fft_done),
      .we           (we),
      .adr          (adr),
      .wd           (wd),
      .fft_start    (fft_start),
      .overrun      (overrun)
   );

   typedef struct {
      int          k;
      logic [23:0] samp;
      logic [4:0]  adr;
      logic [15:0] re;
      bit          chk_re;
   } vec_t;

   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Strobe one sample, then verify the write appears exactly two cycles later.
   task automatic send_chk(input string nm, input logic [23:0] s, input bit c_adr,
                           input logic [4:0] e_adr, input bit c_re, input logic [15:0] e_re);
      sample_in    = s;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk({nm, "_we_early"}, 32'(we), 32'd0);
      tick();
      chk({nm, "_we"}, 32'(we), 32'd1);
      chk({nm, "_imag"}, 32'(wd[15:0]), 32'd0);
      if (c_adr) chk({nm, "_adr"}, 32'(adr), 32'(e_adr));
      if (c_re)  chk({nm, "_real"}, 32'(wd[31:16]), 32'(e_re));
   endtask

   task automatic fill_plain(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         send_chk($sformatf("%s%0d", nm, i), {8'(i), 16'h5A5A}, 1'b0, 5'd0, 1'b0, 16'h0);
      end
   endtask

   initial begin
      tbl[0] = '{0,  HANN ? 24'h7FFF00 : 24'h123456, 5'd0,  HANN ? 16'h0000 : 16'h1234, 1'b1};
      tbl[1] = '{1,  24'h800000, 5'd16, 16'h8000, !HANN};
      tbl[2] = '{2,  24'h7FFFFF, 5'd8,  16'h7FFF, !HANN};
      tbl[3] = '{3,  24'hFFFFFF, 5'd24, 16'hFFFF, !HANN};
      tbl[4] = '{4,  24'h00ABCD, 5'd4,  16'h00AB, !HANN};
      tbl[5] = '{16, 24'h123456, 5'd1,  HANN ? 16'h1233 : 16'h1234, 1'b1};
      tbl[6] = '{31, 24'hABCDEF, 5'd31, 16'hABCD, !HANN};

      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      fft_ready    = 1'b0;
      fft_done     = 1'b0;
      tick();
      tick();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_adr", 32'(adr), 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_start", 32'(fft_start), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;

      // Full fill with the FFT busy, then the start handshake
      for (int k = 0; k < 32; k++) begin
         int idx;
         idx = -1;
         for (int j = 0; j < 7; j++) if (tbl[j].k == k) idx = j;
         if (idx >= 0)
            send_chk($sformatf("fill_k%0d", k), tbl[idx].samp, 1'b1, tbl[idx].adr,
                     tbl[idx].chk_re, tbl[idx].re);
         else
            send_chk($sformatf("fill_k%0d", k), {8'(k), 16'h00F0}, 1'b0, 5'd0, 1'b0, 16'h0);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("busy_nostart%0d", i), 32'(fft_start), 32'd0);
      end
      fft_ready = 1'b1;
      #1;
      chk("start_pulse", 32'(fft_start), 32'd1);
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (fft_start) pulses++;
         end
         chk("start_single", 32'(pulses), 32'd0);
      end

      // Samples while the FFT owns the RAM are dropped
      sample_in    = 24'h333333;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("wait_overrun", 32'(overrun), 32'd1);
      tick();
      chk("wait_nowrite0", 32'(we), 32'd0);
      tick();
      chk("wait_nowrite1", 32'(we), 32'd0);
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      send_chk("refill_k0", 24'h0F0F0F, 1'b1, 5'd0, 1'b1, HANN ? 16'h0000 : 16'h0F0F);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Fresh run: FFT ready early, fft_done during FILL ignored, start waits for last write
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_overrun", 32'(overrun), 32'd0);
      fft_ready = 1'b1;
      fill_plain("c_a", 5);
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      fill_plain("c_b", 26);
      sample_in    = 24'h010203;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("gate_inflight", 32'(fft_start), 32'd0);
      tick();
      chk("gate_last_we", 32'(we), 32'd1);
      chk("gate_writing", 32'(fft_start), 32'd0);
      tick();
      chk("gate_start", 32'(fft_start), 32'd1);
      tick();
      chk("gate_after", 32'(fft_start), 32'd0);

      // fft_done and sample_valid together: sample dropped
      fft_done     = 1'b1;
      sample_in    = 24'h777777;
      sample_valid = 1'b1;
      tick();
      fft_done     = 1'b0;
      sample_valid = 1'b0;
      chk("done_same_overrun", 32'(overrun), 32'd1);
      tick();
      chk("done_same_nowrite0", 32'(we), 32'd0);
      tick();
      chk("done_same_nowrite1", 32'(we), 32'd0);
      send_chk("done_next_k0", 24'h0F0F0F, 1'b1, 5'd0, 1'b1, HANN ? 16'h0000 : 16'h0F0F);

      // Reset at k=10 with a write in flight, competing with other inputs
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fill_plain("d_", 10);
      sample_in    = 24'h222222;
      sample_valid = 1'b1;
      tick();
      reset    = 1'b1;
      fft_done = 1'b1;
      tick();
      reset        = 1'b0;
      fft_done     = 1'b0;
      sample_valid = 1'b0;
      chk("flush_we0", 32'(we), 32'd0);
      tick();
      chk("flush_we1", 32'(we), 32'd0);
      chk("flush_overrun", 32'(overrun), 32'd0);
      send_chk("post_rst_k0", 24'h456789, 1'b1, 5'd0, 1'b1, HANN ? 16'h0000 : 16'h4567);
      chk("post_rst_overrun", 32'(overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
